// File: rtl/ext_ram_arbiter.sv
// ext_ram_arbiter: round-robin arbiter and pin sequencer for the external RAM.
// Ports: CPU and loader request ports (req/we/addr/wdata -> rdata/ack/err),
//   RAM pins (ram_addr, ram_we, ram_oe, ram_dout, ram_din, ram_dq_oe), busy.
module ext_ram_arbiter #(
    parameter int ADDR_W        = 5,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [7:0]        ldr_addr,
    input  logic [7:0]        ldr_wdata,
    output logic [7:0]        ldr_rdata,
    output logic              ldr_ack,
    output logic              ldr_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dq_oe,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [3:0] LP_CNT = 4'(STROBE_CYCLES - 1);

    state_t            r_state;
    logic              r_last;   // 1 = loader won the last grant
    logic              r_gnt;    // 1 = loader owns the access in flight
    logic              r_we;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic              r_ram_oe;
    logic [7:0]        r_ram_dout;
    logic [7:0]        r_dq_oe;
    logic [7:0]        r_cpu_rdata;
    logic [7:0]        r_ldr_rdata;
    logic              r_cpu_ack;
    logic              r_ldr_ack;
    logic              r_cpu_err;
    logic              r_ldr_err;
    logic              r_busy;

    logic              w_pick_ldr;
    logic              w_we;
    logic [7:0]        w_addr;
    logic [7:0]        w_wdata;
    logic              w_oor;

    // On a tie the port that did not win last time gets the grant.
    assign w_pick_ldr = ldr_req & (~cpu_req | ~r_last);
    assign w_we       = w_pick_ldr ? ldr_we    : cpu_we;
    assign w_addr     = w_pick_ldr ? ldr_addr  : cpu_addr;
    assign w_wdata    = w_pick_ldr ? ldr_wdata : cpu_wdata;
    assign w_oor      = |(w_addr >> ADDR_W);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_gnt       <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_oe    <= 1'b0;
            r_ram_dout  <= 8'h00;
            r_dq_oe     <= 8'h00;
            r_cpu_rdata <= 8'h00;
            r_ldr_rdata <= 8'h00;
            r_cpu_ack   <= 1'b0;
            r_ldr_ack   <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_ldr_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cpu_req | ldr_req) begin
                        r_gnt  <= w_pick_ldr;
                        r_last <= w_pick_ldr;
                        r_we   <= w_we;
                        r_busy <= 1'b1;
                        if (w_oor) begin
                            // Out of range: skip the pin cycle entirely.
                            r_state <= S_DONE;
                            if (w_pick_ldr) begin
                                r_ldr_ack   <= 1'b1;
                                r_ldr_err   <= 1'b1;
                                r_ldr_rdata <= 8'h00;
                            end else begin
                                r_cpu_ack   <= 1'b1;
                                r_cpu_err   <= 1'b1;
                                r_cpu_rdata <= 8'h00;
                            end
                        end else begin
                            r_state    <= S_SETUP;
                            r_ram_addr <= w_addr[ADDR_W-1:0];
                            if (w_we) begin
                                r_ram_dout <= w_wdata;
                                r_dq_oe    <= 8'hFF;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    r_state  <= S_STROBE;
                    r_ram_we <= r_we;
                    r_ram_oe <= ~r_we;
                    r_cnt    <= LP_CNT;
                end
                S_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= S_HOLD;
                        r_ram_we <= 1'b0;
                        r_ram_oe <= 1'b0;
                        // Read data is taken on the last edge OE is high.
                        if (!r_we) begin
                            if (r_gnt) r_ldr_rdata <= ram_din;
                            else       r_cpu_rdata <= ram_din;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    r_state <= S_DONE;
                    r_dq_oe <= 8'h00;
                    if (r_gnt) begin
                        r_ldr_ack <= 1'b1;
                        r_ldr_err <= 1'b0;
                    end else begin
                        r_cpu_ack <= 1'b1;
                        r_cpu_err <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_cpu_ack <= 1'b0;
                    r_ldr_ack <= 1'b0;
                    r_cpu_err <= 1'b0;
                    r_ldr_err <= 1'b0;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_err   = r_cpu_err;
    assign ldr_rdata = r_ldr_rdata;
    assign ldr_ack   = r_ldr_ack;
    assign ldr_err   = r_ldr_err;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_oe    = r_ram_oe;
    assign ram_dout  = r_ram_dout;
    assign ram_dq_oe = r_dq_oe;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ext_ram_arbiter.sv
// tb_ext_ram_arbiter: scoreboard bench for ext_ram_arbiter.
// Drives directed accesses; a negedge monitor checks every ack against a queue.
module tb_ext_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
    logic [7:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;

    logic [7:0] cpu_rdata0, ldr_rdata0, ram_dout0, ram_din0, ram_dq_oe0;
    logic       cpu_ack0, cpu_err0, ldr_ack0, ldr_err0;
    logic       ram_we0, ram_oe0, busy0;
    logic [4:0] ram_addr0;

    logic [7:0] cpu_rdata1, ldr_rdata1, ram_dout1, ram_din1, ram_dq_oe1;
    logic       cpu_ack1, cpu_err1, ldr_ack1, ldr_err1;
    logic       ram_we1, ram_oe1, busy1;
    logic [4:0] ram_addr1;

    always #5 clk = ~clk;

    ext_ram_arbiter #(.ADDR_W(5), .STROBE_CYCLES(2)) u0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0), .cpu_ack(cpu_ack0),
        .cpu_err(cpu_err0),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata0), .ldr_ack(ldr_ack0),
        .ldr_err(ldr_err0),
        .ram_addr(ram_addr0), .ram_we(ram_we0), .ram_oe(ram_oe0),
        .ram_dout(ram_dout0), .ram_din(ram_din0), .ram_dq_oe(ram_dq_oe0),
        .busy(busy0)
    );

    ext_ram_arbiter #(.ADDR_W(5), .STROBE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1),
        .cpu_err(cpu_err1),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata1), .ldr_ack(ldr_ack1),
        .ldr_err(ldr_err1),
        .ram_addr(ram_addr1), .ram_we(ram_we1), .ram_oe(ram_oe1),
        .ram_dout(ram_dout1), .ram_din(ram_din1), .ram_dq_oe(ram_dq_oe1),
        .busy(busy1)
    );

    // RAM models: data only appears on the pins while OE is high.
    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];
    initial begin
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        mem0[31] = 8'h5C;
        mem1[31] = 8'h5C;
    end
    always @(posedge clk) if (ram_we0) mem0[ram_addr0] <= ram_dout0;
    always @(posedge clk) if (ram_we1) mem1[ram_addr1] <= ram_dout1;
    assign ram_din0 = ram_oe0 ? mem0[ram_addr0] : 8'hEE;
    assign ram_din1 = ram_oe1 ? mem1[ram_addr1] : 8'hEE;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         ldr;
        logic [7:0] rdata;
        bit         err;
        int         cyc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: pin invariants every cycle, scoreboard on every ack.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if ((ram_we0 && ram_oe0) || (ram_we1 && ram_oe1) ||
            (ram_oe0 && ram_dq_oe0 != 8'h00) ||
            (busy0 === 1'b0 && ram_dq_oe0 != 8'h00)) begin
            failures++;
            $display("FAIL pins cyc=%0d we=%b oe=%b dq=%h busy=%b",
                     cyc, ram_we0, ram_oe0, ram_dq_oe0, busy0);
        end
        if (cpu_ack0 === 1'b1 || ldr_ack0 === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack cyc=%0d cpu=%b ldr=%b",
                         cyc, cpu_ack0, ldr_ack0);
            end else begin
                e = q.pop_front();
                if ((e.ldr ? ldr_ack0 : cpu_ack0) !== 1'b1 ||
                    (e.ldr ? cpu_ack0 : ldr_ack0) !== 1'b0 ||
                    cyc != e.cyc ||
                    (e.ldr ? ldr_rdata0 : cpu_rdata0) !== e.rdata ||
                    (e.ldr ? ldr_err0 : cpu_err0) !== e.err) begin
                    failures++;
                    $display("FAIL ack cyc=%0d want=%0d ldr=%b cpu_ack=%b ldr_ack=%b rd=%h/%h want %h err=%b/%b want %b",
                             cyc, e.cyc, e.ldr, cpu_ack0, ldr_ack0,
                             cpu_rdata0, ldr_rdata0, e.rdata,
                             cpu_err0, ldr_err0, e.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] t_addr [8];
    logic [7:0] t_dq   [8];
    logic [7:0] t_dout [8];
    logic       t_we   [8];
    logic       t_oe   [8];
    logic       t_busy [8];

    task automatic run(input bit ldr, input bit we, input logic [7:0] a,
                       input logic [7:0] wd, input logic [7:0] rd,
                       input bit err, input int lat);
        exp_t e;
        if (ldr) begin
            ldr_req = 1; ldr_we = we; ldr_addr = a; ldr_wdata = wd;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
        e.ldr = ldr; e.rdata = rd; e.err = err; e.cyc = cyc + lat;
        q.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            tick();
            t_addr[k] = 8'(ram_addr0);
            t_dq[k]   = ram_dq_oe0;
            t_dout[k] = ram_dout0;
            t_we[k]   = ram_we0;
            t_oe[k]   = ram_oe0;
            t_busy[k] = busy0;
        end
        cpu_req = 0;
        ldr_req = 0;
    endtask

    initial begin
        exp_t e;
        int   c;
        int   n_oe;
        logic [7:0] acks1;
        logic [7:0] rd1;
        logic [7:0] dq_or;

        tick();
        tick();
        chk("reset_pins", {ram_we0, ram_oe0, ram_dq_oe0, 3'b0, ram_addr0,
                           ram_dout0}, 64'h0);
        chk("reset_port", {cpu_rdata0, ldr_rdata0, cpu_ack0, ldr_ack0,
                           cpu_err0, ldr_err0, busy0}, 64'h0);
        rst_n = 1;
        tick();

        // CPU write 0xA5 to 0x03.
        run(0, 1, 8'h03, 8'hA5, 8'h00, 0, 5);
        chk("wr_c1_addr", t_addr[1], 8'h03);
        chk("wr_c1_dq", t_dq[1], 8'hFF);
        chk("wr_c1_we", t_we[1], 1'b0);
        chk("wr_c2_we", t_we[2], 1'b1);
        chk("wr_c3_we", t_we[3], 1'b1);
        chk("wr_c4_we", t_we[4], 1'b0);
        chk("wr_c4_dout", t_dout[4], 8'hA5);
        chk("wr_c4_dq", t_dq[4], 8'hFF);
        chk("wr_busy", t_busy[1], 1'b1);
        tick();

        // Loader read of 0x1F.
        run(1, 0, 8'h1F, 8'h00, 8'h5C, 0, 5);
        dq_or = 8'h00;
        for (int k = 1; k <= 5; k++) dq_or |= t_dq[k];
        chk("rd_dq", dq_or, 8'h00);
        chk("rd_oe", {t_oe[1], t_oe[2], t_oe[3], t_oe[4]}, 4'b0110);
        chk("rd_cpu_rdata", cpu_rdata0, 8'h00);
        tick();

        // Both ports requesting continuously: CPU, loader, CPU, loader.
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h03;
        ldr_req = 1; ldr_we = 0; ldr_addr = 8'h1F;
        c = cyc;
        for (int i = 0; i < 4; i++) begin
            e.ldr = i[0];
            e.rdata = i[0] ? 8'h5C : 8'hA5;
            e.err = 0;
            e.cyc = c + 5 + 6 * i;
            q.push_back(e);
        end
        repeat (23) tick();
        cpu_req = 0;
        ldr_req = 0;
        tick();

        // Out-of-range CPU read.
        run(0, 0, 8'h20, 8'h00, 8'h00, 1, 1);
        chk("oor_pins", {t_we[1], t_oe[1], t_dq[1]}, 10'h0);
        chk("oor_busy", t_busy[1], 1'b1);
        tick();

        // Reset during the second strobe cycle of a write.
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h05; cpu_wdata = 8'h77;
        repeat (3) tick();
        chk("rst_mid_we", ram_we0, 1'b1);
        rst_n = 0;
        tick();
        chk("rst_abort", {ram_we0, ram_oe0, ram_dq_oe0, busy0, cpu_ack0},
            12'h0);
        cpu_req = 0;
        rst_n = 1;
        tick();
        run(0, 0, 8'h03, 8'h00, 8'hA5, 0, 5);
        tick();

        // Short strobe build: read ack one cycle earlier, OE for one cycle.
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h03;
        e.ldr = 0; e.rdata = 8'hA5; e.err = 0; e.cyc = cyc + 5;
        q.push_back(e);
        n_oe = 0;
        acks1 = 8'h00;
        rd1 = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (ram_oe1) n_oe++;
            acks1[k] = cpu_ack1;
            if (k == 4) rd1 = cpu_rdata1;
        end
        cpu_req = 0;
        chk("s1_ack", acks1, 8'b0001_0000);
        chk("s1_oe", n_oe, 1);
        chk("s1_rdata", rd1, 8'hA5);
        tick();

        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_ram_arbiter.md
# ext_ram_arbiter

Sequencer and two-port arbiter for the 32-byte external RAM on the Neander-X TinyTapeout pins. It takes word requests from the CPU core and from the program loader/debug port, and grants them round-robin. It runs each granted access as a fixed setup/strobe/hold pin cycle on the address, WE, OE and bidirectional data pins, then returns a one-cycle acknowledge with read data to the winner.

## Interface
Parameters:
- ADDR_W, 5, number of RAM address pins; RAM size is 2^ADDR_W bytes
- STROBE_CYCLES, 2, cycles WE/OE stay asserted; legal range 1..15

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  reset; synchronous and active-low
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  8  byte address; stable while cpu_req
- cpu_wdata  in  8  write data; stable while cpu_req
- cpu_rdata  out  8  read data; valid with cpu_ack and held until the next CPU ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  valid with cpu_ack; 1 = address out of range
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack, ldr_err  same directions, widths and meanings for the loader port
- ram_addr  out  ADDR_W  RAM address pins
- ram_we  out  1  RAM write enable, active high
- ram_oe  out  1  RAM output enable, active high
- ram_dout  out  8  data pins, output path
- ram_din  in  8  data pins, input path
- ram_dq_oe  out  8  data pin direction; all 1 = drive, all 0 = input
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - Samples both requests.
  - Only one requester active → it wins.
  - Both active → the one not granted last wins. A 1-bit last_grant register records the last winner; its reset value is "loader", so the CPU wins the first tie.
  - The winner's we/addr/wdata are latched into internal registers. Port inputs are ignored until DONE.
- Range check: if the latched address has any bit in [7:ADDR_W] set, the FSM goes IDLE → DONE with err=1 and rdata=0x00. No RAM pin toggles.
- SETUP, one cycle:
  - ram_addr = latched address; ram_we = ram_oe = 0.
  - On a write, ram_dout = wdata and ram_dq_oe = 0xFF.
- STROBE, STROBE_CYCLES cycles, using a down-counter:
  - Write: ram_we = 1. Read: ram_oe = 1.
  - Address and data stay unchanged.
  - On a read, ram_din is captured into the winner's rdata register at the final STROBE edge.
- HOLD, one cycle:
  - ram_we = ram_oe = 0.
  - Address, dout and dq_oe stay held, so write data outlasts WE by one cycle.
- DONE, one cycle:
  - The winner's ack = 1 with err.
  - ram_dq_oe = 0x00; ram_addr keeps its last value.
  - The FSM returns to IDLE.
- Only the granted port's rdata is updated; the other port's rdata is untouched.
- A requester must drop req on the edge where it sees ack. If req is still high in the next IDLE, that is a new request.
- ram_we and ram_oe are never high together. ram_dq_oe is 0x00 during every read and in IDLE.

## Timing
- All outputs are registered; no combinational path exists from inputs to pins.
- In-range access latency, counted from the IDLE cycle where req is sampled high:
  - ack appears in cycle 3 + STROBE_CYCLES, which is 5 at the default.
  - The next access can be sampled in the cycle after ack.
  - Minimum pitch is 4 + STROBE_CYCLES cycles.
- Out-of-range access: ack in cycle 1 after sampling.
- Reset is synchronous: with rst_n low at an edge, on that edge:
  - FSM → IDLE; last_grant → loader.
  - ram_we = ram_oe = 0, ram_dq_oe = 0x00, ram_addr = 0, ram_dout = 0x00.
  - cpu_rdata = ldr_rdata = 0x00; acks, errs and busy = 0.
- Reset mid-access aborts the access with no ack. A strobe in progress drops at that same edge.
- Request changes during SETUP through DONE have no effect on the access in flight.

## Test plan
- Single CPU write, addr 0x03, data 0xA5, default params:
  - Cycle 1: ram_addr = 3, dq_oe = 0xFF, we = 0.
  - Cycles 2-3: we = 1.
  - Cycle 4: we = 0, dout still 0xA5.
  - Cycle 5: cpu_ack = 1, err = 0.
- Loader read, addr 0x1F, RAM model returns 0x5C while oe = 1:
  - ldr_ack in cycle 5, ldr_rdata = 0x5C.
  - dq_oe = 0x00 throughout; cpu_rdata unchanged.
- Both requesters held high continuously for four accesses: grants alternate CPU, loader, CPU, loader; each ack is 6 cycles apart.
- CPU read at addr 0x20 (out of range): cpu_ack in cycle 1 with err = 1 and rdata = 0x00; ram_we, ram_oe and dq_oe never assert.
- rst_n driven low during the second STROBE cycle of a write:
  - Next edge: we = 0, dq_oe = 0x00, busy = 0, no ack.
  - A subsequent read request completes normally.
- Rebuild with STROBE_CYCLES = 1:
  - Read ack in cycle 4, with oe high for exactly 1 cycle.
  - Check across all tests that we and oe are never high together.
